// File: rtl/gray_receiver.sv
// Gray-coded count receiver: one input pipeline stage, then decode, step classification
// against the previously accepted sample, lock FSM and saturating error counter.
module gray_receiver #(
    parameter int M     = 3,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [M-1:0]     gray_in,
    input  logic             valid,
    input  logic             clr_err,
    output logic [M-1:0]     bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             dir_down,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StLocked   = 2'd1,
        StSuspect  = 2'd2
    } state_e;

    localparam logic [M-1:0]     OneM   = {{(M-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

    function automatic logic [M-1:0] gray2bin(input logic [M-1:0] g);
        logic [M-1:0] b;
        b[M-1] = g[M-1];
        for (int i = M - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Input capture stage: the sample taken here is classified on the following edge.
    logic             r_in_valid;
    logic [M-1:0]     r_in_gray;

    logic [M-1:0]     r_prev_gray;
    state_e           r_state;
    logic [M-1:0]     r_bin;
    logic             r_bin_valid;
    logic             r_step_err;
    logic             r_dir_down;
    logic [ERR_W-1:0] r_err_count;

    logic [M-1:0]     w_new_bin;
    logic [M-1:0]     w_prev_bin;
    logic [M-1:0]     w_diff;
    logic             w_zero;
    logic             w_single;
    logic             w_up;
    state_e           w_state_d;
    logic             w_step_err_d;
    logic             w_dir_down_d;
    logic             w_err_inc;
    logic [ERR_W-1:0] w_err_count_d;

    assign w_new_bin  = gray2bin(r_in_gray);
    assign w_prev_bin = gray2bin(r_prev_gray);
    assign w_diff     = r_in_gray ^ r_prev_gray;
    assign w_zero     = (w_diff == '0);
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign w_single   = !w_zero && ((w_diff & (w_diff - OneM)) == '0);
    assign w_up       = (w_new_bin == (w_prev_bin + OneM));

    always_comb begin
        w_state_d    = r_state;
        w_step_err_d = 1'b0;
        w_dir_down_d = r_dir_down;
        w_err_inc    = 1'b0;
        if (r_in_valid) begin
            unique case (r_state)
                StUnlocked: begin
                    w_state_d = StLocked;
                end
                StLocked, StSuspect: begin
                    if (w_single) begin
                        w_state_d    = StLocked;
                        w_dir_down_d = !w_up;
                    end else if (!w_zero) begin
                        w_step_err_d = 1'b1;
                        w_err_inc    = 1'b1;
                        w_state_d    = (r_state == StLocked) ? StSuspect : StUnlocked;
                    end
                end
                default: begin
                    w_state_d = StUnlocked;
                end
            endcase
        end
    end

    always_comb begin
        w_err_count_d = r_err_count;
        if (clr_err) begin
            w_err_count_d = '0;
        end else if (w_err_inc && (r_err_count != ErrMax)) begin
            w_err_count_d = r_err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_valid  <= 1'b0;
            r_in_gray   <= '0;
            r_prev_gray <= '0;
            r_state     <= StUnlocked;
            r_bin       <= '0;
            r_bin_valid <= 1'b0;
            r_step_err  <= 1'b0;
            r_dir_down  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_in_valid  <= valid;
            if (valid) begin
                r_in_gray <= gray_in;
            end
            r_bin_valid <= r_in_valid;
            r_step_err  <= w_step_err_d;
            r_err_count <= w_err_count_d;
            if (r_in_valid) begin
                r_state     <= w_state_d;
                r_prev_gray <= r_in_gray;
                r_bin       <= w_new_bin;
                r_dir_down  <= w_dir_down_d;
            end
        end
    end

    assign bin_out   = r_bin;
    assign bin_valid = r_bin_valid;
    assign step_err  = r_step_err;
    assign dir_down  = r_dir_down;
    assign locked    = (r_state == StLocked);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_gray_receiver.sv
// Self-checking bench for gray_receiver: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model (two counter widths).
module tb_gray_receiver;

    logic       clk;
    logic       rst_n;
    logic [2:0] gray_in;
    logic       valid;
    logic       clr_err;

    logic [2:0] a_bin_out, b_bin_out;
    logic       a_bin_valid, b_bin_valid;
    logic       a_step_err, b_step_err;
    logic       a_dir_down, b_dir_down;
    logic       a_locked, b_locked;
    logic [7:0] a_err_count;
    logic [1:0] b_err_count;

    gray_receiver #(.M(3), .ERR_W(8)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .valid     (valid),
        .clr_err   (clr_err),
        .bin_out   (a_bin_out),
        .bin_valid (a_bin_valid),
        .step_err  (a_step_err),
        .dir_down  (a_dir_down),
        .locked    (a_locked),
        .err_count (a_err_count)
    );

    gray_receiver #(.M(3), .ERR_W(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .valid     (valid),
        .clr_err   (clr_err),
        .bin_out   (b_bin_out),
        .bin_valid (b_bin_valid),
        .step_err  (b_step_err),
        .dir_down  (b_dir_down),
        .locked    (b_locked),
        .err_count (b_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = unlocked, 1 = locked, 2 = suspect.
    int         m_st;
    logic [2:0] m_prev;
    logic [2:0] m_bin;
    bit         m_bv, m_se, m_dir;
    int         m_err_a, m_err_b;
    bit         p_v;
    logic [2:0] p_g;

    function automatic logic [2:0] dec(input logic [2:0] g);
        return g ^ (g >> 1) ^ (g >> 2);
    endfunction

    task automatic model_reset();
        m_st = 0; m_prev = '0; m_bin = '0; m_bv = 0; m_se = 0; m_dir = 0;
        m_err_a = 0; m_err_b = 0; p_v = 0; p_g = '0;
    endtask

    task automatic model_edge(input bit c);
        int         d;
        logic [2:0] delta;
        m_bv = p_v;
        m_se = 0;
        if (p_v) begin
            m_bin = dec(p_g);
            d = $countones(p_g ^ m_prev);
            if (m_st == 0) begin
                m_st = 1;
            end else if (d == 1) begin
                delta = dec(p_g) - dec(m_prev);
                m_dir = (delta != 3'd1);
                m_st  = 1;
            end else if (d >= 2) begin
                m_se = 1;
                if (m_err_a < 255) m_err_a++;
                if (m_err_b < 3) m_err_b++;
                m_st = (m_st == 1) ? 2 : 0;
            end
            m_prev = p_g;
        end
        if (c) begin
            m_err_a = 0;
            m_err_b = 0;
        end
    endtask

    task automatic step(input bit v, input logic [2:0] g, input bit c);
        valid   = v;
        gray_in = g;
        clr_err = c;
        @(posedge clk);
        #1;
        model_edge(c);
        p_v = v;
        p_g = g;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " a.bin_out"}, a_bin_out, m_bin);
        chk({tag, " a.bin_valid"}, a_bin_valid, m_bv);
        chk({tag, " a.step_err"}, a_step_err, m_se);
        chk({tag, " a.dir_down"}, a_dir_down, m_dir);
        chk({tag, " a.locked"}, a_locked, m_st == 1);
        chk({tag, " a.err_count"}, a_err_count, m_err_a);
        chk({tag, " b.bin_out"}, b_bin_out, m_bin);
        chk({tag, " b.step_err"}, b_step_err, m_se);
        chk({tag, " b.locked"}, b_locked, m_st == 1);
        chk({tag, " b.err_count"}, b_err_count, m_err_b);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " a.outs"}, {a_bin_out, a_bin_valid, a_step_err, a_dir_down, a_locked,
            a_err_count}, 0);
        chk({tag, " b.outs"}, {b_bin_out, b_bin_valid, b_step_err, b_dir_down, b_locked,
            b_err_count}, 0);
    endtask

    typedef struct {
        logic [2:0] g;
        logic [2:0] bin;
        logic       se;
        logic       dir;
        logic       lk;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [2:0] last_g;
        logic [2:0] sat_seq[10];

        // Sample, then expected outputs once that sample has been processed.
        tbl[0]  = '{3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[1]  = '{3'b001, 3'd1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[2]  = '{3'b011, 3'd2, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[3]  = '{3'b010, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[4]  = '{3'b110, 3'd4, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[5]  = '{3'b100, 3'd7, 1'b0, 1'b1, 1'b1, 8'd0};
        tbl[6]  = '{3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[8]  = '{3'b100, 3'd7, 1'b0, 1'b1, 1'b1, 8'd0};
        tbl[9]  = '{3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[10] = '{3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{3'b010, 3'd3, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[12] = '{3'b101, 3'd6, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[13] = '{3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[14] = '{3'b111, 3'd5, 1'b0, 1'b0, 1'b1, 8'd3};

        sat_seq = '{3'b000, 3'b011, 3'b010, 3'b101, 3'b100,
                    3'b011, 3'b010, 3'b101, 3'b100, 3'b011};

        valid = 0; gray_in = '0; clr_err = 0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed table: each sample followed by an idle cycle, checked when it emerges.
        for (int i = 0; i < 15; i++) begin
            step(1'b1, tbl[i].g, 1'b0);
            step(1'b0, 3'b000, 1'b0);
            chk($sformatf("tbl%0d bin_out", i), a_bin_out, tbl[i].bin);
            chk($sformatf("tbl%0d bin_valid", i), a_bin_valid, 1'b1);
            chk($sformatf("tbl%0d step_err", i), a_step_err, tbl[i].se);
            chk($sformatf("tbl%0d dir_down", i), a_dir_down, tbl[i].dir);
            chk($sformatf("tbl%0d locked", i), a_locked, tbl[i].lk);
            chk($sformatf("tbl%0d err_count", i), a_err_count, tbl[i].err);
        end
        step(1'b0, 3'b000, 1'b0);
        chk("pulse bin_valid low", a_bin_valid, 1'b0);
        chk("pulse step_err low", a_step_err, 1'b0);

        // Saturation: five illegal steps with valid held high.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, sat_seq[i], 1'b0);
            check_model($sformatf("sat%0d", i));
            if (i >= 1) chk($sformatf("sat%0d continuous bin_valid", i), a_bin_valid, 1'b1);
        end
        step(1'b0, 3'b000, 1'b0);
        check_model("sat flush");
        chk("sat a.err_count", a_err_count, 8'd5);
        chk("sat b.err_count", b_err_count, 2'd3);

        // clr_err on the same edge as an error detection.
        step(1'b1, 3'b010, 1'b0);
        step(1'b1, 3'b101, 1'b0);
        step(1'b0, 3'b000, 1'b1);
        check_model("clr collide");
        chk("clr collide step_err", a_step_err, 1'b1);
        chk("clr collide a.err_count", a_err_count, 8'd0);
        chk("clr collide b.err_count", b_err_count, 2'd0);
        step(1'b0, 3'b000, 1'b0);

        // Asynchronous reset with a sample in flight.
        step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 3'b000, 1'b0);
        chk("post-reset bin_valid", a_bin_valid, 1'b0);
        step(1'b1, 3'b101, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        check_model("post-reset first");
        chk("post-reset step_err", a_step_err, 1'b0);
        chk("post-reset locked", a_locked, 1'b1);
        chk("post-reset bin_out", a_bin_out, 3'd6);

        // Randomized traffic against the model.
        last_g = 3'b101;
        for (int n = 0; n < 400; n++) begin
            bit         v, c;
            int         kind;
            logic [2:0] g, b;
            v    = ($urandom_range(0, 9) < 7);
            c    = ($urandom_range(0, 29) == 0);
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                b = dec(last_g);
                b = ($urandom_range(0, 1) == 1) ? b + 3'd1 : b - 3'd1;
                g = b ^ (b >> 1);
            end else if (kind < 7) begin
                g = last_g;
            end else begin
                g = 3'($urandom_range(0, 7));
            end
            if (v) last_g = g;
            step(v, g, c);
            check_model($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_receiver.md
GRAY_RECEIVER -- requirements
Module: gray_receiver

Interface
REQ-001 Parameter M, default 3: width of Gray-coded input and binary output, M >= 2.
REQ-002 Parameter ERR_W, default 8: width of error counter, ERR_W >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 gray_in  input  M  Gray-coded count sample, synchronous to clk.
REQ-006 valid  input  1  gray_in is sampled on a rising edge where valid=1.
REQ-007 clr_err  input  1  synchronous clear of err_count.
REQ-008 bin_out  output  M  binary decode of the last accepted sample, registered.
REQ-009 bin_valid  output  1  one-cycle pulse: bin_out updated.
REQ-010 step_err  output  1  one-cycle pulse, coincident with bin_valid: illegal Gray step detected.
REQ-011 dir_down  output  1  direction of the last legal single-bit step; 1 = down.
REQ-012 locked  output  1  1 only in state LOCKED.
REQ-013 err_count  output  ERR_W  saturating count of illegal steps.

Function
REQ-014 Decode SHALL be b[M-1]=g[M-1], b[i]=b[i+1] XOR g[i] for i=M-2..0.
REQ-015 Latency SHALL be 1 cycle: a sample accepted at edge N gives bin_out, bin_valid, step_err and dir_down at edge N+1 (visible after edge N+1 until the next update).
REQ-016 bin_valid SHALL pulse for exactly one cycle per accepted sample, in every state; with valid held high, it stays high continuously.
REQ-017 Block SHALL hold a reference register prev_gray, loaded with every accepted sample regardless of outcome.
REQ-018 The FSM SHALL have states UNLOCKED, LOCKED and SUSPECT; reset state is UNLOCKED.
REQ-019 In UNLOCKED, an accepted sample SHALL be loaded without a step check (step_err=0, dir_down unchanged), and the FSM SHALL go to LOCKED.
REQ-020 In LOCKED or SUSPECT, an accepted sample SHALL be classified by d = popcount(gray_in XOR prev_gray).
REQ-021 d=0 SHALL be legal: step_err=0, dir_down unchanged, state unchanged.
REQ-022 d=1 SHALL be legal: step_err=0, and the FSM SHALL go to LOCKED.
REQ-023 On d=1, dir_down SHALL be 0 if new binary equals previous binary plus 1 mod 2^M, and 1 otherwise; wrap from 2^M-1 to 0 counts as up, and 0 to 2^M-1 counts as down.
REQ-024 d>=2 SHALL be illegal: step_err=1, err_count increments, dir_down unchanged.
REQ-025 On d>=2, LOCKED SHALL go to SUSPECT, and SUSPECT SHALL go to UNLOCKED.
REQ-026 err_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-027 If clr_err and an error occur on the same edge, clr_err SHALL win and err_count becomes 0.
REQ-028 Samples with valid=0 SHALL be ignored; all registers hold.

Reset
REQ-029 While rst_n=0, and asynchronously on its assertion, the block SHALL be: state UNLOCKED, prev_gray 0, bin_out 0, bin_valid 0, step_err 0, dir_down 0, locked 0, err_count 0.
REQ-030 Reset asserted mid-stream SHALL discard any in-flight sample; the first valid sample after release SHALL be loaded unchecked per REQ-019.

Verification
REQ-031 M=3, valid samples 000,001,011,010,110 -> bin_out 0,1,2,3,4; step_err always 0; dir_down 0; locked=1 from the cycle after the first sample.
REQ-032 Samples 100 (bin 7) then 000 -> bin_out 0 with dir_down=0; then samples 000 then 100 -> bin_out 7 with dir_down=1.
REQ-033 From LOCKED at 000: sample 011 -> step_err pulse, err_count=1, locked=0; then 010 -> no error, locked=1.
REQ-034 From LOCKED: two consecutive illegal samples -> err_count +2, state UNLOCKED; the next arbitrary sample -> step_err=0, locked=1.
REQ-035 ERR_W=2: 5 illegal steps -> err_count stays 3; clr_err on the same edge as an illegal step -> err_count=0 with step_err=1.
REQ-036 rst_n pulsed low mid-stream -> all outputs 0 immediately, without waiting for clk; the first sample after release is not checked.
